dff9_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter for a shared 9-bit register (dff_9bit). NUM_REQ requesters

---
 rtl/dff9_wr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dff9_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff9_wr_arbiter.sv
// Purpose : round-robin arbiter for the single write port of a shared register, with bounded lock bursts.
// Latency : req sampled at edge E -> gnt/reg_wen/reg_d valid after E; the register shows the data one edge later.
// Backpr. : requesters hold req/wdata until gnt; the grantee's lock holds the port for up to MAX_LOCK extra cycles.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   req, lock     per-requester write request / keep-grant request (lock qualified by req)
//   wdata         packed write data, requester i in wdata[i*WIDTH +: WIDTH]
//   reg_q, rd_q   register value in, passed straight back out for read-modify-write owners
//   reg_d/reg_wen register write data / enable
//   gnt, gnt_id   one-hot grant and grantee index (zero when idle)
//   busy          a grant is active
//   lock_timeout  single-cycle pulse after a lock burst was cut off at MAX_LOCK
module dff9_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 9,
  parameter int MAX_LOCK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  input  logic [WIDTH-1:0]           reg_q,
  output logic [WIDTH-1:0]           rd_q,
  output logic [WIDTH-1:0]           reg_d,
  output logic                       reg_wen,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       lock_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = IDW + 1;               // wide enough for ptr + offset before wrapping
  localparam int CW  = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [IDW-1:0]   owner_d;
  logic             tmo_d;

  logic [NUM_REQ-1:0] gnt_d;
  logic [IDW-1:0]     gnt_id_d;
  logic [WIDTH-1:0]   reg_d_d;
  logic               reg_wen_d;
  logic               busy_d;

  logic [WIDTH-1:0] wd [NUM_REQ];
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [PW-1:0]    pos;
  logic             excl;
  logic             hold;

  assign rd_q = reg_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wd
    assign wd[i] = wdata[i*WIDTH +: WIDTH];
  end

  // gnt_id doubles as the owner register; it is only meaningful outside IDLE.
  assign excl = (state_q != S_IDLE);
  assign hold = req[gnt_id] & lock[gnt_id];

  // Rotating priority scan starting at ptr. The current owner is skipped when
  // it is giving up the port so that it can never win twice in a row.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_q} + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (!win_vld && req[pos[IDW-1:0]] && !(excl && (pos[IDW-1:0] == gnt_id))) begin
        win_vld = 1'b1;
        win     = pos[IDW-1:0];
      end
    end
  end

  // State register (also holds all registered outputs).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      lock_cnt_q   <= '0;
      gnt          <= '0;
      gnt_id       <= '0;
      reg_d        <= '0;
      reg_wen      <= 1'b0;
      busy         <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_cnt_q   <= lock_cnt_d;
      gnt          <= gnt_d;
      gnt_id       <= gnt_id_d;
      reg_d        <= reg_d_d;
      reg_wen      <= reg_wen_d;
      busy         <= busy_d;
      lock_timeout <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    logic new_grant;
    state_d    = state_q;
    owner_d    = gnt_id;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    tmo_d      = 1'b0;
    new_grant  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) new_grant = 1'b1;
      end
      S_GRANT: begin
        if (hold) begin
          state_d    = S_LOCK;
          lock_cnt_d = CW'(1);
        end else if (win_vld) begin
          new_grant = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (hold && (lock_cnt_q < CW'(MAX_LOCK))) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          // Owner still wants the port here only if the burst limit cut it off.
          lock_cnt_d = '0;
          tmo_d      = hold;
          if (win_vld) new_grant = 1'b1;
          else         state_d   = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
      end
    endcase
    if (new_grant) begin
      state_d = S_GRANT;
      owner_d = win;
      ptr_d   = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
    end
  end

  // Output logic: values the output flops take at the coming edge.
  // reg_d keeps its last value while idle so the register input stays quiet.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    reg_wen_d = 1'b0;
    busy_d    = 1'b0;
    reg_d_d   = reg_d;
    if (state_d != S_IDLE) begin
      gnt_d[owner_d] = 1'b1;
      gnt_id_d       = owner_d;
      reg_wen_d      = 1'b1;
      busy_d         = 1'b1;
      reg_d_d        = wd[owner_d];
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_cnt_bound:  assert property (@(posedge clk) disable iff (!rst) lock_cnt_q <= CW'(MAX_LOCK));

endmodule

// File: tb/tb_dff9_wr_arbiter.sv
module tb_dff9_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int ML = 8;

  typedef struct {
    int           cyc;
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic [W-1:0] d;
    logic         wen;
    logic         tmo;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0]   reg_q = '0;
  logic [W-1:0]   rd_q;
  logic [W-1:0]   reg_d;
  logic           reg_wen;
  logic [N-1:0]   gnt;
  logic [1:0]     gnt_id;
  logic           busy;
  logic           lock_timeout;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  exp_t sbq[$];

  // reference model state: current owner (-1 = nobody), locked flag, burst length, rotation start
  int           m_cyc = 0;
  int           m_own = -1;
  int           m_cnt = 0;
  int           m_ptr = 0;
  bit           m_lk  = 1'b0;
  logic [W-1:0] m_d   = '0;

  dff9_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .wdata        (wdata),
    .reg_q        (reg_q),
    .rd_q         (rd_q),
    .reg_d        (reg_d),
    .reg_wen      (reg_wen),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  // the shared 9-bit register
  always @(posedge clk or negedge rst) begin
    if (!rst) reg_q <= '0;
    else if (reg_wen) reg_q <= reg_d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (model cycle %0d)", name, act, exp, m_cyc);
    end else begin
      passes++;
    end
  endtask

  // first requester asking, in rotation order from m_ptr, other than 'ex'
  function automatic int pick(input int ex);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r < 0 && req[i] && i != ex) r = i;
    end
    return r;
  endfunction

  // reference model: decides who owns the port after each edge
  always @(posedge clk) begin : model
    int   o;
    int   w;
    bit   t;
    bit   ng;
    exp_t e;
    m_cyc++;
    if (!rst) begin
      m_own = -1; m_lk = 1'b0; m_cnt = 0; m_ptr = 0; m_d = '0;
      sbq.delete();
    end else begin
      o = m_own; w = -1; t = 1'b0; ng = 1'b0;
      if (o < 0) begin
        w  = pick(-1);
        ng = (w >= 0);
      end else if (req[o] && lock[o] && (!m_lk || m_cnt < ML)) begin
        w     = o;
        m_cnt = m_lk ? m_cnt + 1 : 1;
        m_lk  = 1'b1;
      end else begin
        t     = m_lk && req[o] && lock[o];
        m_lk  = 1'b0;
        m_cnt = 0;
        w     = pick(o);
        ng    = (w >= 0);
      end
      if (ng) m_ptr = (w + 1) % N;
      m_own = w;
      if (w >= 0) m_d = wdata[w*W +: W];
      if (w >= 0 || t) begin
        e.cyc = m_cyc;
        e.gnt = '0;
        if (w >= 0) e.gnt[w] = 1'b1;
        e.id  = (w >= 0) ? w[1:0] : 2'd0;
        e.d   = m_d;
        e.wen = (w >= 0);
        e.tmo = t;
        sbq.push_back(e);
      end
    end
  end

  // monitor: compares DUT outputs with the scoreboard, away from the active edge
  always @(negedge clk) begin : monitor
    exp_t e;
    logic pres;
    logic epres;
    if (rst) begin
      pres  = reg_wen || lock_timeout;
      epres = (sbq.size() > 0) && (sbq[0].cyc == m_cyc);
      chk("output_present", 64'(pres), 64'(epres));
      if (epres) begin
        e = sbq.pop_front();
        chk("sb_entry", {gnt, gnt_id, reg_d, reg_wen, busy, lock_timeout},
            {e.gnt, e.id, e.d, e.wen, e.wen, e.tmo});
      end else if (!pres) begin
        chk("idle_outputs", {gnt, gnt_id, busy}, 64'd0);
      end
      chk("rd_q_passthru", 64'(rd_q), 64'(reg_q));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t3_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {gnt, gnt_id, reg_d, reg_wen, busy, lock_timeout}, 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;

    // single write
    req = 4'b0100;
    wdata[2*W +: W] = 9'h1A5;
    tick();
    chk("t2_grant", {gnt, gnt_id, reg_wen, reg_d}, {4'b0100, 2'd2, 1'b1, 9'h1A5});
    req = '0;
    tick();
    chk("t2_idle_q", {busy, reg_wen, rd_q}, {1'b0, 1'b0, 9'h1A5});

    // move rotation start to 0, then fairness with all requesting
    req = 4'b1000; tick();
    req = '0;      tick();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t3_fair", {gnt_id, reg_wen}, {2'(t3_ids[t]), 1'b1});
    end
    req = '0; tick();

    // RMW lock burst with a competing requester
    req = 4'b1000; tick();
    req = '0;      tick();
    req = 4'b0101; lock = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t4_lock", {gnt, lock_timeout}, {4'b0001, 1'b0});
    end
    req = 4'b0100; lock = '0;
    tick();
    chk("t4_release", {gnt, lock_timeout}, {4'b0100, 1'b0});
    req = '0; tick();

    // forced release at MAX_LOCK
    req = 4'b0011; lock = 4'b0001;
    for (int t = 0; t < ML + 1; t++) begin
      tick();
      chk("t5_hold", {gnt, lock_timeout}, {4'b0001, 1'b0});
    end
    tick();
    chk("t5_timeout", {gnt, lock_timeout}, {4'b0010, 1'b1});
    req = '0; lock = '0;
    tick();
    chk("t5_pulse_end", {gnt, lock_timeout}, 64'd0);

    // pointer wrap
    req = 4'b1010; tick();
    chk("t6_first", {gnt, gnt_id}, {4'b1000, 2'd3});
    req = 4'b0010; tick();
    chk("t6_second", {gnt, gnt_id}, {4'b0010, 2'd1});
    req = '0; tick();
    req = 4'b1111; tick();
    chk("t6_ptr_end", {gnt, gnt_id}, {4'b0100, 2'd2});
    req = '0; tick();

    // asynchronous reset in the middle of a lock burst
    req = 4'b0010; lock = 4'b0010;
    tick();
    tick();
    chk("t1_locked", {gnt, busy}, {4'b0010, 1'b1});
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t1_async_reset", {gnt, gnt_id, reg_d, reg_wen, busy, lock_timeout}, 64'd0);
    req = 4'b0001; lock = '0;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    tick();
    chk("t1_first_after_reset", {gnt, gnt_id}, {4'b0001, 2'd0});
    req = '0; tick();

    // randomized traffic: sticky req/lock with fresh data every cycle
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
        if ($urandom_range(5) == 0) lock[i] = ~lock[i];
        if (gnt[i] && !lock[i] && $urandom_range(1) == 0) req[i] = 1'b0;
        wdata[i*W +: W] = W'($urandom_range(511));
      end
      tick();
    end

    req = '0; lock = '0;
    repeat (4) tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
